// File: rtl/risc_v_core.sv
// risc_v_core: single-cycle RV32I core with separate instruction and data
// memories. One instruction retires on every rising edge while reset is high.
//
// Ports
//   clock                  rising-edge clock
//   reset                  synchronous active-low reset (pc and counters only)
//   start                  redirect pc to {prog_address,2'b00}; in-flight op dropped
//   prog_address           start word index
//   isp_write/address/data instruction-memory load port
//   from_peripheral*       unused inputs
//   to_peripheral*         tied to zero
//   report                 freezes the cycle and retired-instruction counters
module risc_v_core #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_BITS   = 6,
    parameter int OFFSET_BITS  = 3,
    parameter int ADDRESS_BITS = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDRESS_BITS-1:0] prog_address,
    input  logic                    isp_write,
    input  logic [ADDRESS_BITS-1:0] isp_address,
    input  logic [DATA_WIDTH-1:0]   isp_data,
    input  logic [1:0]              from_peripheral,
    input  logic [31:0]             from_peripheral_data,
    input  logic                    from_peripheral_valid,
    output logic [1:0]              to_peripheral,
    output logic [31:0]             to_peripheral_data,
    output logic                    to_peripheral_valid,
    input  logic                    report
);
    localparam int DEPTH = 1 << ADDRESS_BITS;
    // Identifier and cache geometry parameters carry no function.
    localparam int LP_unused_geometry = CORE + INDEX_BITS + OFFSET_BITS;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;

    logic [DATA_WIDTH-1:0] register_file      [0:31];
    logic [DATA_WIDTH-1:0] instruction_memory [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] data_memory        [0:DEPTH-1];

    logic [31:0] r_pc;
    logic [31:0] r_cycle_count;
    logic [31:0] r_retired_count;

    logic [31:0] w_instr, w_pc_plus4, w_rs1_val, w_rs2_val;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_addr, w_dmem_word, w_load_shifted, w_store_bits, w_store_word;
    logic [3:0]  w_store_mask;
    logic [31:0] w_next_pc, w_rd_val;
    logic        w_rd_we, w_mem_we, w_commit;
    logic        w_unused;

    function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub,
                                        input logic sra, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [31:0] res;
        case (f3)
            3'b000:  res = sub ? a - b : a + b;
            3'b001:  res = a << b[4:0];
            3'b010:  res = {31'd0, $signed(a) < $signed(b)};
            3'b011:  res = {31'd0, a < b};
            3'b100:  res = a ^ b;
            3'b101:  res = sra ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  res = a | b;
            default: res = a & b;
        endcase
        return res;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
        logic t;
        case (f3)
            3'b000:  t = (a == b);
            3'b001:  t = (a != b);
            3'b100:  t = ($signed(a) <  $signed(b));
            3'b101:  t = ($signed(a) >= $signed(b));
            3'b110:  t = (a <  b);
            3'b111:  t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Decode
    assign w_instr    = instruction_memory[r_pc[ADDRESS_BITS+1:2]];
    assign w_opcode   = w_instr[6:0];
    assign w_rd       = w_instr[11:7];
    assign w_f3       = w_instr[14:12];
    assign w_rs1      = w_instr[19:15];
    assign w_rs2      = w_instr[24:20];
    assign w_pc_plus4 = r_pc + 32'd4;

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                      w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'd0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                      w_instr[30:21], 1'b0};

    // x0 is hardwired to zero on the read side; the array entry is never written.
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : register_file[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : register_file[w_rs2];

    // Memory access: lanes are picked by addr[1:0], alignment is not enforced.
    assign w_addr         = w_rs1_val + ((w_opcode == OPC_STORE) ? w_imm_s : w_imm_i);
    assign w_dmem_word    = data_memory[w_addr[ADDRESS_BITS+1:2]];
    assign w_load_shifted = w_dmem_word >> {w_addr[1:0], 3'b000};

    always_comb begin
        w_store_mask = 4'b0000;
        case (w_f3)
            3'b000:  w_store_mask = 4'b0001 << w_addr[1:0];
            3'b001:  w_store_mask = 4'b0011 << w_addr[1:0];
            3'b010:  w_store_mask = 4'b1111;
            default: w_store_mask = 4'b0000;
        endcase
    end

    assign w_store_bits = {{8{w_store_mask[3]}}, {8{w_store_mask[2]}},
                           {8{w_store_mask[1]}}, {8{w_store_mask[0]}}};
    assign w_store_word = (w_dmem_word & ~w_store_bits) |
                          ((w_rs2_val << {w_addr[1:0], 3'b000}) & w_store_bits);

    // Execute: anything not decoded below falls through as a NOP.
    always_comb begin
        w_next_pc = w_pc_plus4;
        w_rd_we   = 1'b0;
        w_rd_val  = 32'd0;
        w_mem_we  = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_rd_we  = 1'b1;
                w_rd_val = w_imm_u;
            end
            OPC_AUIPC: begin
                w_rd_we  = 1'b1;
                w_rd_val = r_pc + w_imm_u;
            end
            OPC_JAL: begin
                w_rd_we   = 1'b1;
                w_rd_val  = w_pc_plus4;
                w_next_pc = r_pc + w_imm_j;
            end
            OPC_JALR: begin
                if (w_f3 == 3'b000) begin
                    w_rd_we   = 1'b1;
                    w_rd_val  = w_pc_plus4;
                    w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
                end
            end
            OPC_BRANCH: begin
                if (branch_taken(w_f3, w_rs1_val, w_rs2_val))
                    w_next_pc = r_pc + w_imm_b;
            end
            OPC_LOAD: begin
                w_rd_we = 1'b1;
                case (w_f3)
                    3'b000:  w_rd_val = {{24{w_load_shifted[7]}}, w_load_shifted[7:0]};
                    3'b001:  w_rd_val = {{16{w_load_shifted[15]}}, w_load_shifted[15:0]};
                    3'b010:  w_rd_val = w_load_shifted;
                    3'b100:  w_rd_val = {24'd0, w_load_shifted[7:0]};
                    3'b101:  w_rd_val = {16'd0, w_load_shifted[15:0]};
                    default: w_rd_we  = 1'b0;
                endcase
            end
            OPC_STORE: w_mem_we = (w_store_mask != 4'b0000);
            OPC_IMM: begin
                w_rd_we  = 1'b1;
                w_rd_val = alu(w_f3, 1'b0, w_instr[30], w_rs1_val, w_imm_i);
            end
            OPC_REG: begin
                w_rd_we  = 1'b1;
                w_rd_val = alu(w_f3, w_instr[30], w_instr[30], w_rs1_val, w_rs2_val);
            end
            default: ;
        endcase
    end

    // An instruction commits only out of reset and when not being redirected by start.
    assign w_commit = reset && !start;

    // State update
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc            <= 32'd0;
            r_cycle_count   <= 32'd0;
            r_retired_count <= 32'd0;
        end else begin
            if (!report)
                r_cycle_count <= r_cycle_count + 32'd1;
            if (start) begin
                r_pc <= {{(30-ADDRESS_BITS){1'b0}}, prog_address, 2'b00};
            end else begin
                r_pc <= w_next_pc;
                if (!report)
                    r_retired_count <= r_retired_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_commit && w_rd_we && (w_rd != 5'd0))
            register_file[w_rd] <= w_rd_val;
    end

    always_ff @(posedge clock) begin
        if (w_commit && w_mem_we)
            data_memory[w_addr[ADDRESS_BITS+1:2]] <= w_store_word;
    end

    // The loader port works regardless of reset so images can be written while
    // the core is held.
    always_ff @(posedge clock) begin
        if (isp_write)
            instruction_memory[isp_address] <= isp_data;
    end

    assign to_peripheral       = 2'd0;
    assign to_peripheral_data  = 32'd0;
    assign to_peripheral_valid = 1'b0;

    assign w_unused = ^{from_peripheral, from_peripheral_data, from_peripheral_valid,
                        w_addr[31:ADDRESS_BITS+2]};

endmodule

// File: tb/tb_risc_v_core.sv
// Self-checking bench for risc_v_core. Programs are loaded through the ISP
// port while reset is held low; expected register values are queued when a
// program is built and popped against the register file after it runs.
module tb_risc_v_core;
    localparam int AB = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AB-1:0] prog_address = '0;
    logic          isp_write = 1'b0;
    logic [AB-1:0] isp_address = '0;
    logic [31:0]   isp_data = '0;
    logic [1:0]    from_peripheral = 2'b11;
    logic [31:0]   from_peripheral_data = 32'hdeadbeef;
    logic          from_peripheral_valid = 1'b1;
    logic [1:0]    to_peripheral;
    logic [31:0]   to_peripheral_data;
    logic          to_peripheral_valid;
    logic          report = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] prog[$];

    risc_v_core #(.ADDRESS_BITS(AB)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .start                 (start),
        .prog_address          (prog_address),
        .isp_write             (isp_write),
        .isp_address           (isp_address),
        .isp_data              (isp_data),
        .from_peripheral       (from_peripheral),
        .from_peripheral_data  (from_peripheral_data),
        .from_peripheral_valid (from_peripheral_valid),
        .to_peripheral         (to_peripheral),
        .to_peripheral_data    (to_peripheral_data),
        .to_peripheral_valid   (to_peripheral_valid),
        .report                (report)
    );

    always #5 clock = ~clock;

    // Instruction encoders
    function automatic logic [31:0] f_i(input int op, input int f3, input int rd,
                                        input int rs1, input int imm);
        logic [31:0] o, f, d, s, v;
        o = op; f = f3; d = rd; s = rs1; v = imm;
        return {v[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] f_r(input int f7, input int f3, input int rd,
                                        input int rs1, input int rs2);
        logic [31:0] g, f, d, s, t;
        g = f7; f = f3; d = rd; s = rs1; t = rs2;
        return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] f_s(input int f3, input int rs1, input int rs2,
                                        input int imm);
        logic [31:0] f, s, t, v;
        f = f3; s = rs1; t = rs2; v = imm;
        return {v[11:5], t[4:0], s[4:0], f[2:0], v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] f_b(input int f3, input int rs1, input int rs2,
                                        input int imm);
        logic [31:0] f, s, t, v;
        f = f3; s = rs1; t = rs2; v = imm;
        return {v[12], v[10:5], t[4:0], s[4:0], f[2:0], v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] f_u(input int op, input int rd, input int imm20);
        logic [31:0] o, d, v;
        o = op; d = rd; v = imm20;
        return {v[19:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] f_j(input int rd, input int imm);
        logic [31:0] d, v;
        d = rd; v = imm;
        return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6f};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return f_i('h13, 0, rd, rs1, imm);
    endfunction

    task automatic push_exp(input string name, input int idx, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.idx  = idx;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Writes prog (zero padded to 64 words) with the core held in reset, then releases it.
    task automatic load_prog();
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            isp_write   = 1'b1;
            isp_address = AB'(i);
            isp_data    = (i < prog.size()) ? prog[i] : 32'h0;
            step(1);
        end
        isp_write = 1'b0;
        step(1);
        reset = 1'b1;
    endtask

    task automatic clear_regs();
        prog.delete();
        for (int i = 1; i < 32; i++) prog.push_back(addi(i, 0, 0));
        prog.push_back(f_j(0, 0));
        load_prog();
        step(32);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(2);
        n_cmp++;
        if (dut.r_pc !== 32'h0) begin
            n_bad++; $display("FAIL reset_pc: got %h want %h", dut.r_pc, 32'h0);
        end
        n_cmp++;
        if (dut.r_cycle_count !== 32'h0) begin
            n_bad++; $display("FAIL reset_cycles: got %h want %h", dut.r_cycle_count, 32'h0);
        end
        n_cmp++;
        if (dut.r_retired_count !== 32'h0) begin
            n_bad++; $display("FAIL reset_retired: got %h want %h", dut.r_retired_count, 32'h0);
        end
        n_cmp++;
        if ({to_peripheral, to_peripheral_data, to_peripheral_valid} !== 35'h0) begin
            n_bad++; $display("FAIL tied_outputs: got %h want 0",
                              {to_peripheral, to_peripheral_data, to_peripheral_valid});
        end
    endtask

    task automatic test_bltu();
        exp_t e;
        clear_regs();
        prog.delete();
        prog.push_back(f_u('h37, 11, 'h00001));
        prog.push_back(f_u('h37, 12, 'h80000));
        prog.push_back(f_u('h37, 13, 'hfffff));
        prog.push_back(f_b(6, 11, 12, 8));
        prog.push_back(addi(16, 0, 'h7ff));
        prog.push_back(f_b(6, 12, 13, 8));
        prog.push_back(addi(16, 0, 'h7ff));
        prog.push_back(f_r(0, 0, 14, 13, 0));
        prog.push_back(f_b(6, 13, 12, 8));
        prog.push_back(addi(15, 12, 0));
        prog.push_back(addi(16, 11, 1));
        prog.push_back(f_j(0, 0));
        for (int i = 0; i < 32; i++) begin
            case (i)
                11:      push_exp("bltu_a1", i, 32'h00001000);
                12:      push_exp("bltu_a2", i, 32'h80000000);
                13:      push_exp("bltu_a3", i, 32'hfffff000);
                14:      push_exp("bltu_a4", i, 32'hfffff000);
                15:      push_exp("bltu_a5", i, 32'h80000000);
                16:      push_exp("bltu_a6", i, 32'h00001001);
                default: push_exp($sformatf("bltu_x%0d", i), i, 32'h0);
            endcase
        end
        load_prog();
        step(45);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (dut.register_file[e.idx] !== e.val) begin
                n_bad++; $display("FAIL %s: got %h want %h", e.name, dut.register_file[e.idx], e.val);
            end
        end
    endtask

    task automatic test_x0();
        exp_t e;
        clear_regs();
        prog.delete();
        prog.push_back(addi(0, 0, 5));
        prog.push_back(addi(1, 0, 7));
        prog.push_back(f_j(0, 0));
        push_exp("x0_zero", 0, 32'h0);
        push_exp("x0_x1", 1, 32'h7);
        load_prog();
        step(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (dut.register_file[e.idx] !== e.val) begin
                n_bad++; $display("FAIL %s: got %h want %h", e.name, dut.register_file[e.idx], e.val);
            end
        end
    endtask

    task automatic test_jal();
        exp_t e;
        clear_regs();
        prog.delete();
        prog.push_back(f_j(1, 8));
        prog.push_back(addi(2, 0, 1));
        prog.push_back(addi(3, 0, 2));
        prog.push_back(f_j(0, 0));
        push_exp("jal_link", 1, 32'h4);
        push_exp("jal_skipped", 2, 32'h0);
        push_exp("jal_target", 3, 32'h2);
        load_prog();
        step(1);
        n_cmp++;
        if (dut.r_pc !== 32'h8) begin
            n_bad++; $display("FAIL jal_pc: got %h want %h", dut.r_pc, 32'h8);
        end
        step(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (dut.register_file[e.idx] !== e.val) begin
                n_bad++; $display("FAIL %s: got %h want %h", e.name, dut.register_file[e.idx], e.val);
            end
        end
    endtask

    task automatic test_zeros();
        logic [31:0] want;
        clear_regs();
        prog.delete();
        for (int i = 1; i <= 10; i++) pc_q.push_back(32'(4 * i));
        load_prog();
        while (pc_q.size() > 0) begin
            step(1);
            want = pc_q.pop_front();
            n_cmp++;
            if (dut.r_pc !== want) begin
                n_bad++; $display("FAIL zeros_pc: got %h want %h", dut.r_pc, want);
            end
        end
        for (int i = 0; i < 32; i++) begin
            n_cmp++;
            if (dut.register_file[i] !== 32'h0) begin
                n_bad++; $display("FAIL zeros_x%0d: got %h want %h", i, dut.register_file[i], 32'h0);
            end
        end
    endtask

    task automatic test_start();
        exp_t e;
        clear_regs();
        prog.delete();
        for (int i = 0; i < 18; i++) prog.push_back(32'h0);
        prog[0]    = addi(5, 0, 9);
        prog['h10] = addi(6, 0, 3);
        prog['h11] = f_j(0, 0);
        push_exp("start_dropped", 5, 32'h0);
        push_exp("start_target", 6, 32'h3);
        load_prog();
        start        = 1'b1;
        prog_address = 12'h010;
        step(1);
        start = 1'b0;
        n_cmp++;
        if (dut.r_pc !== 32'h40) begin
            n_bad++; $display("FAIL start_pc: got %h want %h", dut.r_pc, 32'h40);
        end
        n_cmp++;
        if (dut.r_retired_count !== 32'h0) begin
            n_bad++; $display("FAIL start_retired: got %h want %h", dut.r_retired_count, 32'h0);
        end
        step(1);
        n_cmp++;
        if (dut.r_pc !== 32'h44) begin
            n_bad++; $display("FAIL start_pc_next: got %h want %h", dut.r_pc, 32'h44);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (dut.register_file[e.idx] !== e.val) begin
                n_bad++; $display("FAIL %s: got %h want %h", e.name, dut.register_file[e.idx], e.val);
            end
        end
    endtask

    task automatic test_load_store();
        exp_t e;
        clear_regs();
        prog.delete();
        prog.push_back(f_u('h37, 1, 'h12345));
        prog.push_back(addi(1, 1, 'h678));
        prog.push_back(addi(2, 0, 'h100));
        prog.push_back(f_s(2, 2, 1, 0));
        prog.push_back(f_i('h03, 0, 3, 2, 3));
        prog.push_back(f_i('h03, 4, 4, 2, 0));
        prog.push_back(f_i('h03, 1, 5, 2, 2));
        prog.push_back(addi(6, 0, -128));
        prog.push_back(f_s(0, 2, 6, 1));
        prog.push_back(f_i('h03, 0, 7, 2, 1));
        prog.push_back(f_i('h03, 5, 8, 2, 0));
        prog.push_back(f_i('h03, 2, 9, 2, 0));
        prog.push_back(f_s(1, 2, 6, 2));
        prog.push_back(f_i('h03, 1, 10, 2, 2));
        prog.push_back(f_i('h03, 2, 11, 2, 0));
        prog.push_back(f_j(0, 0));
        push_exp("ls_lb_off3", 3, 32'h00000012);
        push_exp("ls_lbu_off0", 4, 32'h00000078);
        push_exp("ls_lh_off2", 5, 32'h00001234);
        push_exp("ls_lb_neg", 7, 32'hffffff80);
        push_exp("ls_lhu", 8, 32'h00008078);
        push_exp("ls_lw_after_sb", 9, 32'h12348078);
        push_exp("ls_lh_neg", 10, 32'hffffff80);
        push_exp("ls_lw_after_sh", 11, 32'hff808078);
        load_prog();
        step(20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (dut.register_file[e.idx] !== e.val) begin
                n_bad++; $display("FAIL %s: got %h want %h", e.name, dut.register_file[e.idx], e.val);
            end
        end
        n_cmp++;
        if (dut.data_memory['h40] !== 32'hff808078) begin
            n_bad++; $display("FAIL ls_mem_word: got %h want %h", dut.data_memory['h40], 32'hff808078);
        end
    endtask

    task automatic test_alu_branch();
        exp_t e;
        clear_regs();
        prog.delete();
        prog.push_back(addi(1, 0, -8));                 //   0
        prog.push_back(f_i('h13, 5, 2, 1, 'h401));      //   4 srai
        prog.push_back(f_i('h13, 5, 3, 1, 28));         //   8 srli
        prog.push_back(f_r(0, 2, 4, 1, 0));             //  12 slt
        prog.push_back(f_r(0, 3, 5, 1, 0));             //  16 sltu
        prog.push_back(f_r('h20, 0, 6, 0, 1));          //  20 sub
        prog.push_back(f_r(0, 1, 7, 6, 6));             //  24 sll
        prog.push_back(f_r(0, 4, 8, 1, 6));             //  28 xor
        prog.push_back(f_r(0, 6, 9, 3, 6));             //  32 or
        prog.push_back(f_r(0, 7, 10, 1, 3));            //  36 and
        prog.push_back(f_r('h20, 5, 11, 1, 3));         //  40 sra
        prog.push_back(f_i('h13, 2, 12, 1, -7));        //  44 slti
        prog.push_back(f_i('h13, 3, 13, 1, -7));        //  48 sltiu
        prog.push_back(f_i('h13, 4, 14, 1, -1));        //  52 xori
        prog.push_back(f_i('h13, 6, 15, 0, 'h55));      //  56 ori
        prog.push_back(f_i('h13, 7, 16, 1, 'hff));      //  60 andi
        prog.push_back(f_u('h17, 17, 1));               //  64 auipc
        prog.push_back(f_b(4, 1, 0, 8));                //  68 blt taken
        prog.push_back(addi(20, 0, 'h111));             //  72
        prog.push_back(f_b(5, 0, 1, 8));                //  76 bge taken
        prog.push_back(addi(20, 0, 'h222));             //  80
        prog.push_back(f_b(7, 0, 1, 8));                //  84 bgeu not taken
        prog.push_back(addi(21, 0, 1));                 //  88
        prog.push_back(f_b(0, 0, 0, 8));                //  92 beq taken
        prog.push_back(addi(20, 0, 'h333));             //  96
        prog.push_back(f_b(1, 1, 1, 8));                // 100 bne not taken
        prog.push_back(addi(18, 0, 117));               // 104
        prog.push_back(f_i('h67, 0, 19, 18, 0));        // 108 jalr
        prog.push_back(addi(20, 0, 'h444));             // 112
        prog.push_back(f_i('h13, 1, 22, 21, 31));       // 116 slli
        prog.push_back(f_r(0, 0, 23, 22, 22));          // 120 add wraps
        prog.push_back(f_r(0, 0, 24, 22, 1));           // 124
        prog.push_back(f_j(0, 0));                      // 128
        push_exp("alu_addi_neg", 1, 32'hfffffff8);
        push_exp("alu_srai", 2, 32'hfffffffc);
        push_exp("alu_srli", 3, 32'h0000000f);
        push_exp("alu_slt", 4, 32'h1);
        push_exp("alu_sltu", 5, 32'h0);
        push_exp("alu_sub", 6, 32'h8);
        push_exp("alu_sll", 7, 32'h800);
        push_exp("alu_xor", 8, 32'hfffffff0);
        push_exp("alu_or", 9, 32'hf);
        push_exp("alu_and", 10, 32'h8);
        push_exp("alu_sra", 11, 32'hffffffff);
        push_exp("alu_slti", 12, 32'h1);
        push_exp("alu_sltiu", 13, 32'h1);
        push_exp("alu_xori", 14, 32'h7);
        push_exp("alu_ori", 15, 32'h55);
        push_exp("alu_andi", 16, 32'hf8);
        push_exp("alu_auipc", 17, 32'h1040);
        push_exp("br_jalr_base", 18, 32'h75);
        push_exp("br_jalr_link", 19, 32'h70);
        push_exp("br_skipped", 20, 32'h0);
        push_exp("br_fallthrough", 21, 32'h1);
        push_exp("alu_slli", 22, 32'h80000000);
        push_exp("alu_add_wrap", 23, 32'h0);
        push_exp("alu_add_wrap2", 24, 32'h7ffffff8);
        load_prog();
        step(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (dut.register_file[e.idx] !== e.val) begin
                n_bad++; $display("FAIL %s: got %h want %h", e.name, dut.register_file[e.idx], e.val);
            end
        end
    endtask

    task automatic test_counters_reset();
        exp_t e;
        clear_regs();
        prog.delete();
        prog.push_back(addi(1, 1, 1));
        prog.push_back(f_j(0, -4));
        load_prog();
        step(10);
        n_cmp++;
        if (dut.r_cycle_count !== 32'd10) begin
            n_bad++; $display("FAIL cnt_cycles: got %0d want %0d", dut.r_cycle_count, 10);
        end
        n_cmp++;
        if (dut.r_retired_count !== 32'd10) begin
            n_bad++; $display("FAIL cnt_retired: got %0d want %0d", dut.r_retired_count, 10);
        end
        report = 1'b1;
        step(4);
        report = 1'b0;
        n_cmp++;
        if (dut.r_cycle_count !== 32'd10) begin
            n_bad++; $display("FAIL cnt_frozen_cycles: got %0d want %0d", dut.r_cycle_count, 10);
        end
        n_cmp++;
        if (dut.r_retired_count !== 32'd10) begin
            n_bad++; $display("FAIL cnt_frozen_retired: got %0d want %0d", dut.r_retired_count, 10);
        end
        push_exp("cnt_x1_during_report", 1, 32'd7);
        reset = 1'b0;
        step(1);
        push_exp("rst_x1_kept", 1, 32'd7);
        n_cmp++;
        if (dut.r_pc !== 32'h0 || dut.r_cycle_count !== 32'h0) begin
            n_bad++; $display("FAIL rst_mid_state: got pc %h cycles %0d want pc 0 cycles 0",
                              dut.r_pc, dut.r_cycle_count);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (dut.register_file[e.idx] !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, dut.register_file[e.idx], e.val);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (dut.register_file[e.idx] !== e.val) begin
            n_bad++; $display("FAIL %s: got %h want %h", e.name, dut.register_file[e.idx], e.val);
        end
        reset = 1'b1;
        step(1);
        push_exp("rst_restart_x1", 1, 32'd8);
        n_cmp++;
        if (dut.r_pc !== 32'h4) begin
            n_bad++; $display("FAIL rst_restart_pc: got %h want %h", dut.r_pc, 32'h4);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (dut.register_file[e.idx] !== e.val) begin
                n_bad++; $display("FAIL %s: got %h want %h", e.name, dut.register_file[e.idx], e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bltu();
        test_x0();
        test_jal();
        test_zeros();
        test_start();
        test_load_store();
        test_alu_branch();
        test_counters_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
